// File: rtl/canvas_store.sv
// canvas_store: single-clock canvas memory. One registered read port for the
// display side, one write port shared by the brush stamp engine and the clear
// sweep. Stamps of 1x1..4x4 are written one pixel per cycle with edge clipping.
module canvas_store #(
  parameter int                    MEM_W      = 64,
  parameter int                    MEM_H      = 48,
  parameter int                    COLOR_BITS = 3,
  parameter int                    COORD_BITS = 10,
  parameter logic [COLOR_BITS-1:0] BG_COLOR   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COORD_BITS-1:0] rx,
  input  logic [COORD_BITS-1:0] ry,
  output logic [COLOR_BITS-1:0] rd_color,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [COORD_BITS-1:0] wx,
  input  logic [COORD_BITS-1:0] wy,
  input  logic [COLOR_BITS-1:0] new_color,
  input  logic [1:0]            brush_size,
  input  logic                  clear,
  output logic                  busy
);

  localparam int DEPTH  = MEM_W * MEM_H;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_STAMP} state_t;

  logic [COLOR_BITS-1:0] mem [DEPTH];

  state_t                state;
  logic                  clear_pending;
  logic [ADDR_W-1:0]     sweep;
  logic [COORD_BITS-1:0] sx, sy;
  logic [COLOR_BITS-1:0] scolor;
  logic [1:0]            ssize, dx, dy;

  // Pixel currently visited by the stamp; one extra bit so edges never wrap.
  logic [COORD_BITS:0]   px, py;
  logic                  px_in, stamp_last, sweep_last;
  logic                  we;
  logic [ADDR_W-1:0]     waddr, raddr;
  logic [COLOR_BITS-1:0] wdata;
  logic                  rd_in;

  assign px         = {1'b0, sx} + (COORD_BITS+1)'(dx);
  assign py         = {1'b0, sy} + (COORD_BITS+1)'(dy);
  assign px_in      = (32'(px) < MEM_W) && (32'(py) < MEM_H);
  assign stamp_last = (dx == ssize) && (dy == ssize);
  assign sweep_last = (sweep == ADDR_W'(DEPTH - 1));

  // Ready/busy come from registered state only, never from wr_valid.
  assign wr_ready = (state == S_IDLE) && !clear_pending;
  assign busy     = (state != S_IDLE);

  // Write port mux: clear sweep or an in-bounds stamp pixel; reset suppresses it.
  always_comb begin
    we    = 1'b0;
    waddr = sweep;
    wdata = BG_COLOR;
    if (!reset) begin
      if (state == S_CLEAR) begin
        we = 1'b1;
      end else if (state == S_STAMP && px_in) begin
        we    = 1'b1;
        waddr = ADDR_W'(py) * ADDR_W'(MEM_W) + ADDR_W'(px);
        wdata = scolor;
      end
    end
  end

  assign rd_in = (32'(rx) < MEM_W) && (32'(ry) < MEM_H);
  assign raddr = ADDR_W'(ry) * ADDR_W'(MEM_W) + ADDR_W'(rx);

  // Memory write; the read below sees the old word (read-before-write).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read, out-of-canvas coordinates return the background colour.
  always_ff @(posedge clk) begin
    if (reset)      rd_color <= '0;
    else if (rd_in) rd_color <= mem[raddr];
    else            rd_color <= BG_COLOR;
  end

  // Control FSM: clear sweep, idle/accept, and stamp offset walk (dy outer, dx inner).
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_CLEAR;
      sweep         <= '0;
      clear_pending <= 1'b0;
      sx            <= '0;
      sy            <= '0;
      scolor        <= '0;
      ssize         <= '0;
      dx            <= '0;
      dy            <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (sweep_last) begin
            sweep <= '0;
            // A clear seen during the sweep restarts it once it completes.
            if (clear_pending || clear) begin
              clear_pending <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            sweep <= sweep + 1'b1;
            if (clear) clear_pending <= 1'b1;
          end
        end
        S_IDLE: begin
          if (clear || clear_pending) begin
            state         <= S_CLEAR;
            sweep         <= '0;
            clear_pending <= 1'b0;
          end else if (wr_valid) begin
            state  <= S_STAMP;
            sx     <= wx;
            sy     <= wy;
            scolor <= new_color;
            ssize  <= brush_size;
            dx     <= '0;
            dy     <= '0;
          end
        end
        S_STAMP: begin
          if (clear) clear_pending <= 1'b1;
          if (stamp_last) begin
            state <= S_IDLE;
            dx    <= '0;
            dy    <= '0;
          end else if (dx == ssize) begin
            dx <= '0;
            dy <= dy + 1'b1;
          end else begin
            dx <= dx + 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_store.sv
// Directed bench for canvas_store: stamp table plus hand sequences for
// reset sweep, read-before-write, clear priority, mid-stamp clear and reset.
module tb_canvas_store;

  localparam int W  = 64;
  localparam int H  = 48;
  localparam int CB = 3;
  localparam int KB = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [KB-1:0] rx, ry, wx, wy;
  logic [CB-1:0] rd_color, new_color;
  logic          wr_valid, wr_ready, clear, busy;
  logic [1:0]    brush_size;

  canvas_store #(.MEM_W(W), .MEM_H(H), .COLOR_BITS(CB), .COORD_BITS(KB), .BG_COLOR(3'd0)) dut (
    .clk(clk), .reset(reset), .rx(rx), .ry(ry), .rd_color(rd_color),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wx(wx), .wy(wy),
    .new_color(new_color), .brush_size(brush_size), .clear(clear), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int size; int color;} vec_t;

  int      checks = 0;
  int      errors = 0;
  int      model [W*H];
  vec_t    vt [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int x, input int y, output int c);
    rx = KB'(x);
    ry = KB'(y);
    tick();
    c = int'(rd_color);
  endtask

  task automatic scan(input string name);
    int bad = 0;
    int c;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        rd(x, y, c);
        if (c != model[y*W + x]) bad++;
      end
    chk(name, bad, 0);
  endtask

  task automatic wait_ready(input int bound, output int n);
    n = 0;
    while (!wr_ready && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < W*H; i++) model[i] = 0;
  endtask

  task automatic model_stamp(input int x, input int y, input int size, input int color);
    for (int dy = 0; dy <= size; dy++)
      for (int dx = 0; dx <= size; dx++)
        if (x + dx < W && y + dy < H) model[(y+dy)*W + x + dx] = color;
  endtask

  // Drive one accepted stamp request; returns right after the accept edge.
  task automatic send(input int x, input int y, input int size, input int color);
    wx = KB'(x); wy = KB'(y); brush_size = 2'(size); new_color = CB'(color);
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    int n, c, busy_low, seen7, total;
    vt[0] = '{62, 46, 3, 3};
    vt[1] = '{10, 20, 1, 6};
    vt[2] = '{63,  0, 2, 2};
    vt[3] = '{ 0, 47, 3, 1};

    reset = 1'b1; rx = '0; ry = '0; wx = '0; wy = '0; new_color = '0;
    brush_size = '0; wr_valid = 1'b0; clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 1);
    chk("rst_ready", wr_ready, 0);
    chk("rst_rd", rd_color, 0);

    // Post-reset sweep: ready must stay low for exactly W*H cycles.
    n = 0; busy_low = 0;
    while (!wr_ready && n < 4000) begin
      if (!busy) busy_low++;
      tick();
      n++;
    end
    chk("rst_sweep_len", n, W*H);
    chk("rst_busy_held", busy_low, 0);
    model_zero();
    scan("rst_scan");

    // Single pixel with read-before-write on the write cycle.
    send(5, 7, 0, 5);
    rx = KB'(5); ry = KB'(7);
    tick();
    chk("rbw_old", rd_color, 0);
    chk("px_ready", wr_ready, 1);
    tick();
    chk("rbw_new", rd_color, 5);
    model_stamp(5, 7, 0, 5);
    scan("px_scan");

    // Stamp table: occupancy is N*N cycles, canvas matches clipped model.
    for (int i = 0; i < 4; i++) begin
      send(vt[i].x, vt[i].y, vt[i].size, vt[i].color);
      chk($sformatf("stamp%0d_busy", i), busy, 1);
      wait_ready(100, n);
      chk($sformatf("stamp%0d_len", i), n, (vt[i].size+1)*(vt[i].size+1));
      model_stamp(vt[i].x, vt[i].y, vt[i].size, vt[i].color);
      scan($sformatf("stamp%0d_scan", i));
    end

    rd(64, 0, c);
    chk("oor_x", c, 0);
    rd(0, 48, c);
    chk("oor_y", c, 0);

    // Clear beats a same-cycle stamp request.
    wx = KB'(1); wy = KB'(1); brush_size = 2'd0; new_color = 3'd7;
    wr_valid = 1'b1; clear = 1'b1;
    tick();
    wr_valid = 1'b0; clear = 1'b0;
    chk("clr_busy", busy, 1);
    wait_ready(4000, n);
    chk("clr_len", n, W*H);
    model_zero();
    scan("clr_scan");

    // Clear pulsed mid-stamp: stamp completes, then the canvas is cleared.
    send(0, 0, 3, 7);
    rx = KB'(3); ry = KB'(3);
    total = 1; seen7 = 0;
    for (int k = 0; k < 5; k++) begin tick(); total++; end
    clear = 1'b1;
    tick(); total++;
    clear = 1'b0;
    n = 0;
    while (!wr_ready && n < 4000) begin
      tick();
      n++;
      if (rd_color == 3'd7) seen7 = 1;
    end
    total += n;
    chk("midclr_last_px", seen7, 1);
    chk("midclr_len_ok", int'(total >= 16 + W*H), 1);
    scan("midclr_scan");

    // Reset mid-stamp: three pixels written, the rest abandoned.
    send(20, 20, 3, 4);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy, 1);
    chk("midrst_ready", wr_ready, 0);
    chk("midrst_rd", rd_color, 0);
    rd(20, 20, c);
    chk("midrst_done_px", c, 4);
    rd(23, 20, c);
    chk("midrst_skip_px", c, 0);
    rd(21, 21, c);
    chk("midrst_skip_row", c, 0);
    rd(64, 0, c);
    chk("midrst_oor_x", c, 0);
    rd(0, 48, c);
    chk("midrst_oor_y", c, 0);
    wait_ready(4000, n);
    chk("midrst_sweep_len", n, W*H - 5);
    scan("midrst_scan");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
